pipe_fetch_stage: RTL and testbench
===================================

Name: pipe_fetch_stage

Overview:
- Instruction-fetch stage for the 5-stage pipelined MIPS core; successor to the single-cycle core's PC and next-PC logic.
- Owns the PC register, next-PC selection and the IF/ID pipeline register.
- Adds stall, flush, delayed-branch mode, interrupt/exception vectoring with EPC capture, and kernel-bit protection in PC[31].
- Sits between the instruction ROM (combinational read) and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ILLOP_PC, 32'h80000004, interrupt vector.
- XADR_PC, 32'h80000008, exception vector.
- DELAY_SLOT, 0, 1 = instruction after a branch/jump executes (no flush on redirect); 0 = it is squashed.
- NOP_WORD, 32'h00000000, bubble instruction inserted into IF/ID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  32  current PC, drives ROM Address.
- imem_instr  in  32  ROM Instruction for imem_addr, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump/jr resolved in ID.
- redirect_pc  in  32  target for redirect.
- exc_valid  in  1  decode detected an undefined opcode in the IF/ID instruction.
- irq  in  1  level interrupt request from the timer/peripheral.
- if_id_instr  out  32  latched instruction.
- if_id_pc4  out  32  latched PC+4 (kernel bit preserved).
- if_id_valid  out  1  0 = bubble.
- trap_taken  out  1  one-cycle pulse when a vector is loaded.
- trap_epc  out  32  return address for register 26; valid with trap_taken.

Behaviour:
- Reset (async, low):
  - PC = RESET_PC; if_id_instr = NOP_WORD; if_id_pc4 = 0; if_id_valid = 0.
  - trap_taken = 0; trap_epc = 0.
  - Reset asserted mid-operation discards all state immediately.
- Sequential fetch: pc4 = {PC[31], PC[30:0]+4}. Bit 31 never carries or toggles through increment; 0x7FFFFFFC wraps to 0x00000000.
- Kernel protection: when PC[31]=0, the PC[31] of any redirect target is forced to 0. When PC[31]=1, redirect_pc is used verbatim, so jr may return to user mode.
- Next-PC priority per cycle, highest first:
  1. exc_valid: PC=XADR_PC; trap_epc=if_id_pc4; IF/ID <= bubble; trap_taken=1. Ignores stall.
  2. irq and PC[31]=0 and not stall: PC=ILLOP_PC; trap_epc=PC (current fetch is re-executed); IF/ID <= bubble; trap_taken=1.
  3. stall: PC and IF/ID hold. A redirect presented during stall is not taken; the hazard unit holds redirect_valid until stall deasserts.
  4. redirect_valid: PC=target.
     - DELAY_SLOT=0: IF/ID <= bubble.
     - DELAY_SLOT=1: IF/ID <= {imem_instr, pc4, 1}.
  5. Otherwise: PC=pc4; IF/ID <= {imem_instr, pc4, 1}.
- irq is ignored while PC[31]=1 (kernel mode, no nesting) and while stalled. It is serviced on the first eligible cycle.
- trap_taken is registered: high exactly one cycle after the vectoring edge, low otherwise. trap_epc holds its value until the next trap.
- Latency: imem_instr is visible at if_id_instr one cycle after imem_addr presents it.
- exc_valid and irq together: exception wins; irq remains pending (level) and is taken later only if still asserted and PC[31]=0.

Decomposition:
- Shared package cpu_pkg: vector constants (RESET_PC, ILLOP_PC, XADR_PC), NOP_WORD, register indices XP=26 and RA=31, next-PC select encoding (SEL_SEQ, SEL_REDIR, SEL_IRQ, SEL_EXC, SEL_HOLD).
- One natural sub-module: pc_next_sel. Combinational priority/mux with the kernel-bit rule; outputs the selected PC, the select code and the bubble flag. The top level holds the PC, IF/ID and trap registers.

Test Plan:
- Reset then free run, ROM words A,B,C at 0x0,0x4,0x8 -> imem_addr 0,4,8,C on successive cycles; if_id shows A/0x4/valid=1, then B/0x8.
- stall high 2 cycles at PC=0x8 -> imem_addr stays 0x8 and IF/ID holds B/0x8; fetch resumes at 0xC after release.
- redirect_valid with redirect_pc=0x40 at PC=0x10:
  - DELAY_SLOT=0 -> next PC 0x40, if_id_valid=0.
  - DELAY_SLOT=1 -> if_id holds the 0x10 instruction with valid=1.
- User-mode redirect to 0x80000100 at PC=0x20 -> PC becomes 0x00000100.
- irq at PC=0x14 (user) -> PC=0x80000004, trap_epc=0x14, trap_taken one-cycle pulse, bubble. irq held while in kernel -> no second trap.
- exc_valid and irq same cycle, if_id_pc4=0x30 -> PC=0x80000008, trap_epc=0x30. Then assert reset mid-stream -> PC=0, if_id_valid=0, trap_taken=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the pipelined MIPS core: reset/trap vectors,
// the bubble word, register indices and the next-PC select encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned XP = 26;
  localparam int unsigned RA = 31;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_IRQ,
    SEL_EXC,
    SEL_HOLD
  } pc_sel_e;

  // Kernel bit is never touched by the increment; the low 31 bits wrap.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pipe_fetch_stage_pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage, including the
// kernel-bit protection applied to redirect targets.
module pc_next_sel #(
  parameter logic [31:0] ILLOP_PC   = cpu_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC    = cpu_pkg::XADR_PC,
  parameter int unsigned DELAY_SLOT = 0
) (
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_exc_valid,
  input  logic        i_irq,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc4,
  output cpu_pkg::pc_sel_e o_sel,
  output logic        o_bubble
);
  import cpu_pkg::*;

  logic [31:0] w_target;
  logic        w_irq_ok;

  assign o_pc4    = pc_plus4(i_pc);
  // A user-mode PC can never redirect into kernel space.
  assign w_target = i_pc[31] ? i_redirect_pc : {1'b0, i_redirect_pc[30:0]};
  assign w_irq_ok = i_irq && !i_pc[31] && !i_stall;

  always_comb begin
    o_sel     = SEL_SEQ;
    o_next_pc = o_pc4;
    o_bubble  = 1'b0;
    if (i_exc_valid) begin
      o_sel     = SEL_EXC;
      o_next_pc = XADR_PC;
      o_bubble  = 1'b1;
    end else if (w_irq_ok) begin
      o_sel     = SEL_IRQ;
      o_next_pc = ILLOP_PC;
      o_bubble  = 1'b1;
    end else if (i_stall) begin
      o_sel     = SEL_HOLD;
      o_next_pc = i_pc;
    end else if (i_redirect_valid) begin
      o_sel     = SEL_REDIR;
      o_next_pc = w_target;
      o_bubble  = (DELAY_SLOT == 0);
    end
  end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and trap
// (interrupt/exception) vectoring with EPC capture.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] ILLOP_PC   = cpu_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC    = cpu_pkg::XADR_PC,
  parameter int unsigned DELAY_SLOT = 0,
  parameter logic [31:0] NOP_WORD   = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic        irq,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        trap_taken,
  output logic [31:0] trap_epc
);
  import cpu_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;
  logic        r_trap_taken;
  logic [31:0] r_trap_epc;

  logic [31:0] w_next_pc;
  logic [31:0] w_pc4;
  pc_sel_e     w_sel;
  logic        w_bubble;

  pc_next_sel #(
    .ILLOP_PC   (ILLOP_PC),
    .XADR_PC    (XADR_PC),
    .DELAY_SLOT (DELAY_SLOT)
  ) u_pc_next_sel (
    .i_pc             (r_pc),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_exc_valid      (exc_valid),
    .i_irq            (irq),
    .o_next_pc        (w_next_pc),
    .o_pc4            (w_pc4),
    .o_sel            (w_sel),
    .o_bubble         (w_bubble)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_if_instr   <= NOP_WORD;
      r_if_pc4     <= '0;
      r_if_valid   <= 1'b0;
      r_trap_taken <= 1'b0;
      r_trap_epc   <= '0;
    end else begin
      r_trap_taken <= 1'b0;
      if (w_sel != SEL_HOLD) begin
        r_pc <= w_next_pc;
        if (w_bubble) begin
          r_if_instr <= NOP_WORD;
          r_if_pc4   <= '0;
          r_if_valid <= 1'b0;
        end else begin
          r_if_instr <= imem_instr;
          r_if_pc4   <= w_pc4;
          r_if_valid <= 1'b1;
        end
      end
      // Exception returns past the faulting decode; interrupt re-executes the fetch.
      if (w_sel == SEL_EXC) begin
        r_trap_taken <= 1'b1;
        r_trap_epc   <= r_if_pc4;
      end else if (w_sel == SEL_IRQ) begin
        r_trap_taken <= 1'b1;
        r_trap_epc   <= r_pc;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_if_instr;
  assign if_id_pc4   = r_if_pc4;
  assign if_id_valid = r_if_valid;
  assign trap_taken  = r_trap_taken;
  assign trap_epc    = r_trap_epc;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Self-checking bench for pipe_fetch_stage: directed plan plus random stimulus
// against a behavioural model, run on a DELAY_SLOT=0 and a DELAY_SLOT=1 instance.
module tb_pipe_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifi;
    logic [31:0] ifpc4;
    logic        ifv;
    logic        tt;
    logic [31:0] epc;
  } mstate_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        exc_valid = 1'b0;
  logic        irq = 1'b0;

  logic [31:0] addr  [2];
  logic [31:0] instr [2];
  logic [31:0] ifi   [2];
  logic [31:0] ifpc4 [2];
  logic        ifv   [2];
  logic        tt    [2];
  logic [31:0] epc   [2];

  mstate_t m [2];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] + 16'h1234};
  endfunction

  assign instr[0] = rom(addr[0]);
  assign instr[1] = rom(addr[1]);

  pipe_fetch_stage #(.DELAY_SLOT(0)) u_dut_ds0 (
    .clk(clk), .reset(reset), .imem_addr(addr[0]), .imem_instr(instr[0]),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .irq(irq), .if_id_instr(ifi[0]), .if_id_pc4(ifpc4[0]),
    .if_id_valid(ifv[0]), .trap_taken(tt[0]), .trap_epc(epc[0])
  );

  pipe_fetch_stage #(.DELAY_SLOT(1)) u_dut_ds1 (
    .clk(clk), .reset(reset), .imem_addr(addr[1]), .imem_instr(instr[1]),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .irq(irq), .if_id_instr(ifi[1]), .if_id_pc4(ifpc4[1]),
    .if_id_valid(ifv[1]), .trap_taken(tt[1]), .trap_epc(epc[1])
  );

  function automatic mstate_t model_reset();
    mstate_t s;
    s.pc = 32'h0; s.ifi = 32'h0; s.ifpc4 = 32'h0; s.ifv = 1'b0;
    s.tt = 1'b0; s.epc = 32'h0;
    return s;
  endfunction

  // One clock of the fetch stage, straight from the priority rules.
  function automatic mstate_t model_step(mstate_t s, bit ds, bit st, bit rv,
                                         logic [31:0] rpc, bit ex, bit iq);
    mstate_t n = s;
    logic [31:0] seq = {s.pc[31], 31'((s.pc & 32'h7FFF_FFFF) + 32'd4)};
    logic [31:0] tgt = s.pc[31] ? rpc : (rpc & 32'h7FFF_FFFF);
    n.tt = 1'b0;
    if (ex) begin
      n.pc = 32'h8000_0008; n.epc = s.ifpc4; n.tt = 1'b1;
      n.ifi = 32'h0; n.ifv = 1'b0;
    end else if (iq && s.pc[31] == 1'b0 && !st) begin
      n.pc = 32'h8000_0004; n.epc = s.pc; n.tt = 1'b1;
      n.ifi = 32'h0; n.ifv = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (rv) begin
      n.pc = tgt;
      if (ds) begin n.ifi = rom(s.pc); n.ifpc4 = seq; n.ifv = 1'b1; end
      else    begin n.ifi = 32'h0; n.ifv = 1'b0; end
    end else begin
      n.pc = seq; n.ifi = rom(s.pc); n.ifpc4 = seq; n.ifv = 1'b1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pc[%0d]", k), addr[k], m[k].pc);
      check($sformatf("if_instr[%0d]", k), ifi[k], m[k].ifi);
      check($sformatf("if_valid[%0d]", k), {31'b0, ifv[k]}, {31'b0, m[k].ifv});
      if (m[k].ifv) check($sformatf("if_pc4[%0d]", k), ifpc4[k], m[k].ifpc4);
      check($sformatf("trap_taken[%0d]", k), {31'b0, tt[k]}, {31'b0, m[k].tt});
      check($sformatf("trap_epc[%0d]", k), epc[k], m[k].epc);
    end
  endtask

  task automatic step(input bit st, input bit rv, input logic [31:0] rpc,
                      input bit ex, input bit iq);
    stall = st; redirect_valid = rv; redirect_pc = rpc; exc_valid = ex; irq = iq;
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], (k == 1), st, rv, rpc, ex, iq);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m[0] = model_reset();
    m[1] = model_reset();
    #2;
    check_all();
    check("reset_pc", addr[0], 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Free run: 0 -> 4 -> 8
    step(0, 0, '0, 0, 0);
    check("seq_pc4", addr[0], 32'h4);
    check("seq_ifA", ifi[0], rom(32'h0));
    step(0, 0, '0, 0, 0);
    check("seq_pc8", addr[0], 32'h8);
    check("seq_ifB_pc4", ifpc4[0], 32'h8);

    // Stall two cycles at 0x8, then resume
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 1);
    check("stall_hold_pc", addr[0], 32'h8);
    check("stall_hold_if", ifi[0], rom(32'h4));
    step(0, 0, '0, 0, 0);
    check("resume_pc", addr[0], 32'hC);
    step(0, 0, '0, 0, 0);

    // Redirect at 0x10 to 0x40
    step(0, 1, 32'h40, 0, 0);
    check("redir_pc", addr[0], 32'h40);
    check("redir_bubble_ds0", {31'b0, ifv[0]}, 32'h0);
    check("redir_slot_ds1", ifi[1], rom(32'h10));
    check("redir_slot_v_ds1", {31'b0, ifv[1]}, 32'h1);

    // User redirect into kernel space is masked
    step(0, 1, 32'h20, 0, 0);
    step(0, 1, 32'h8000_0100, 0, 0);
    check("kernel_mask", addr[0], 32'h0000_0100);

    // IRQ at 0x14 in user mode, then held in kernel
    step(0, 1, 32'h14, 0, 0);
    step(0, 0, '0, 0, 1);
    check("irq_pc", addr[0], 32'h8000_0004);
    check("irq_epc", epc[0], 32'h14);
    check("irq_pulse", {31'b0, tt[0]}, 32'h1);
    step(0, 0, '0, 0, 1);
    check("irq_no_nest_pc", addr[0], 32'h8000_0008);
    check("irq_pulse_end", {31'b0, tt[0]}, 32'h0);

    // Kernel returns to 0x2C, fetch one, then exc+irq together
    step(0, 1, 32'h2C, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 1);
    check("exc_pc", addr[0], 32'h8000_0008);
    check("exc_epc", epc[0], 32'h30);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      bit st = ($urandom_range(3) == 0);
      bit rv = ($urandom_range(5) == 0);
      logic [31:0] rpc = {$urandom_range(1) == 1 ? 1'b1 : 1'b0, 23'($urandom), 8'($urandom_range(63) * 4)};
      bit iq = ($urandom_range(7) == 0);
      bit ex = ($urandom_range(15) == 0) && m[0].ifv && m[1].ifv;
      step(st, rv, rpc, ex, iq);
    end

    // Asynchronous reset mid-stream
    #3;
    reset = 1'b0;
    #1;
    m[0] = model_reset();
    m[1] = model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
